// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch-side signals: ROM port, decode handshake, redirect,
// halt/step control and status. The master modport is the sequencer side.
interface fetch_sequencer_if;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic [15:0] oIssuePC;
  logic        oValid;
  logic        iReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        iHalt;
  logic        iStep;
  logic        oFlush;
  logic        oHalted;
  logic [15:0] oIssueCount;

  modport master (
    output oAddress, oInstruction, oIssuePC, oValid, oFlush, oHalted, oIssueCount,
    input  iInstruction, iReady, iBranchTaken, iBranchTarget, iHalt, iStep
  );

  modport slave (
    input  oAddress, oInstruction, oIssuePC, oValid, oFlush, oHalted, oIssueCount,
    output iInstruction, iReady, iBranchTaken, iBranchTarget, iHalt, iStep
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address from the PC, registers
// one instruction at a time toward decode, with redirect, halt and single-step.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'd0,
  parameter logic        START_HALTED = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [27:0] instr_q;
  logic [15:0] issue_pc_q;
  logic        valid_q;
  logic        flush_q;
  logic        halted_q;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        xfer;

  assign xfer    = valid_q & bus.iReady;
  assign count_d = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);

  // Single-register FSM; all outputs are state-aligned registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= START_HALTED ? S_HALT : S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 28'd0;
      issue_pc_q <= 16'd0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= START_HALTED;
      count_q    <= 16'd0;
    end else begin
      flush_q <= 1'b0;
      // A transfer is counted even when a same-cycle redirect discards the refill.
      if (xfer) begin
        count_q <= count_d;
      end
      case (state_q)
        S_FETCH, S_STEP: begin
          if (bus.iBranchTaken) begin
            pc_q     <= bus.iBranchTarget;
            valid_q  <= 1'b0;
            flush_q  <= 1'b1;
            state_q  <= bus.iHalt ? S_HALT : S_FETCH;
            halted_q <= bus.iHalt;
          end else begin
            instr_q    <= bus.iInstruction;
            issue_pc_q <= pc_q;
            pc_q       <= pc_q + 16'd1;
            valid_q    <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.iBranchTaken) begin
            pc_q     <= bus.iBranchTarget;
            valid_q  <= 1'b0;
            flush_q  <= 1'b1;
            state_q  <= bus.iHalt ? S_HALT : S_FETCH;
            halted_q <= bus.iHalt;
          end else if (xfer && bus.iHalt) begin
            valid_q  <= 1'b0;
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (xfer) begin
            instr_q    <= bus.iInstruction;
            issue_pc_q <= pc_q;
            pc_q       <= pc_q + 16'd1;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_HALT: begin
          if (!bus.iHalt) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
          end else if (bus.iStep) begin
            state_q  <= S_STEP;
            halted_q <= 1'b0;
          end else begin
            state_q <= S_HALT;
          end
        end
        default: begin
          state_q  <= S_FETCH;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oAddress     = pc_q;
  assign bus.oInstruction = instr_q;
  assign bus.oIssuePC     = issue_pc_q;
  assign bus.oValid       = valid_q;
  assign bus.oFlush       = flush_q;
  assign bus.oHalted      = halted_q;
  assign bus.oIssueCount  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the cycle-by-cycle
// sequence, plus hand-written reset, saturation and START_HALTED checks.
module tb_fetch_sequencer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 Clock = ~Clock;

  fetch_sequencer_if bus ();
  fetch_sequencer_if bus2 ();

  // ROM model: word[n] = n
  assign bus.iInstruction  = {12'd0, bus.oAddress};
  assign bus2.iInstruction = {12'd0, bus2.oAddress};

  fetch_sequencer dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  fetch_sequencer #(.RESET_PC(16'h1234), .START_HALTED(1'b1)) dut2 (
    .Clock(Clock), .Reset(Reset), .bus(bus2));

  typedef struct {
    logic        rdy, halt, step, br;
    logic [15:0] tgt;
    logic        valid;
    logic [15:0] ipc, addr;
    logic        flush, halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[36];

  function automatic vec_t v(input logic rdy, halt, step, br, input logic [15:0] tgt,
                             input logic valid, input logic [15:0] ipc, addr,
                             input logic flush, halted, input logic [15:0] cnt);
    vec_t r;
    r.rdy = rdy; r.halt = halt; r.step = step; r.br = br; r.tgt = tgt;
    r.valid = valid; r.ipc = ipc; r.addr = addr; r.flush = flush;
    r.halted = halted; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " valid"},  {31'd0, bus.oValid}, 32'd0);
    chk({tag, " addr"},   {16'd0, bus.oAddress}, 32'd0);
    chk({tag, " ipc"},    {16'd0, bus.oIssuePC}, 32'd0);
    chk({tag, " instr"},  {4'd0, bus.oInstruction}, 32'd0);
    chk({tag, " flush"},  {31'd0, bus.oFlush}, 32'd0);
    chk({tag, " halted"}, {31'd0, bus.oHalted}, 32'd0);
    chk({tag, " count"},  {16'd0, bus.oIssueCount}, 32'd0);
  endtask

  initial begin
    //               rdy hlt stp br tgt       val ipc      addr     fl hl cnt
    vecs[0]  = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd0,    16'd1,    1'b0, 1'b0, 16'd0);
    vecs[1]  = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd1,    16'd2,    1'b0, 1'b0, 16'd1);
    vecs[2]  = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd2,    16'd3,    1'b0, 1'b0, 16'd2);
    vecs[3]  = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd3);
    vecs[4]  = v(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd3);
    vecs[5]  = v(1'b0, 1'b1, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd3);
    vecs[6]  = v(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd3);
    vecs[7]  = v(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd3);
    vecs[8]  = v(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd3);
    vecs[9]  = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd4,    16'd5,    1'b0, 1'b0, 16'd4);
    vecs[10] = v(1'b1, 1'b0, 1'b0, 1'b1, 16'd15,    1'b0, 16'd0,    16'd15,   1'b1, 1'b0, 16'd5);
    vecs[11] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd15,   16'd16,   1'b0, 1'b0, 16'd5);
    vecs[12] = v(1'b1, 1'b0, 1'b0, 1'b1, 16'd2,     1'b0, 16'd0,    16'd2,    1'b1, 1'b0, 16'd6);
    vecs[13] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd2,    16'd3,    1'b0, 1'b0, 16'd6);
    vecs[14] = v(1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 16'd0,    16'd3,    1'b0, 1'b1, 16'd7);
    vecs[15] = v(1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 16'd0,    16'd3,    1'b0, 1'b1, 16'd7);
    vecs[16] = v(1'b1, 1'b1, 1'b1, 1'b0, 16'd0,     1'b0, 16'd0,    16'd3,    1'b0, 1'b0, 16'd7);
    vecs[17] = v(1'b0, 1'b1, 1'b0, 1'b0, 16'd0,     1'b1, 16'd3,    16'd4,    1'b0, 1'b0, 16'd7);
    vecs[18] = v(1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 16'd0,    16'd4,    1'b0, 1'b1, 16'd8);
    vecs[19] = v(1'b1, 1'b1, 1'b1, 1'b0, 16'd0,     1'b0, 16'd0,    16'd4,    1'b0, 1'b0, 16'd8);
    vecs[20] = v(1'b0, 1'b1, 1'b0, 1'b0, 16'd0,     1'b1, 16'd4,    16'd5,    1'b0, 1'b0, 16'd8);
    vecs[21] = v(1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 16'd0,    16'd5,    1'b0, 1'b1, 16'd9);
    vecs[22] = v(1'b1, 1'b1, 1'b1, 1'b0, 16'd0,     1'b0, 16'd0,    16'd5,    1'b0, 1'b0, 16'd9);
    vecs[23] = v(1'b0, 1'b1, 1'b0, 1'b0, 16'd0,     1'b1, 16'd5,    16'd6,    1'b0, 1'b0, 16'd9);
    vecs[24] = v(1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 16'd0,    16'd6,    1'b0, 1'b1, 16'd10);
    vecs[25] = v(1'b1, 1'b1, 1'b0, 1'b1, 16'd100,   1'b0, 16'd0,    16'd6,    1'b0, 1'b1, 16'd10);
    vecs[26] = v(1'b1, 1'b0, 1'b1, 1'b0, 16'd0,     1'b0, 16'd0,    16'd6,    1'b0, 1'b0, 16'd10);
    vecs[27] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd6,    16'd7,    1'b0, 1'b0, 16'd10);
    vecs[28] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'd7,    16'd8,    1'b0, 1'b0, 16'd11);
    vecs[29] = v(1'b1, 1'b0, 1'b1, 1'b0, 16'd0,     1'b1, 16'd8,    16'd9,    1'b0, 1'b0, 16'd12);
    vecs[30] = v(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE,  1'b0, 16'd0,    16'hFFFE, 1'b1, 1'b0, 16'd13);
    vecs[31] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 16'd13);
    vecs[32] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'd14);
    vecs[33] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'd15);
    vecs[34] = v(1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'd16);
    vecs[35] = v(1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'd16);

    bus.iReady = 1'b0; bus.iHalt = 1'b0; bus.iStep = 1'b0;
    bus.iBranchTaken = 1'b0; bus.iBranchTarget = 16'd0;
    bus2.iReady = 1'b1; bus2.iHalt = 1'b1; bus2.iStep = 1'b0;
    bus2.iBranchTaken = 1'b0; bus2.iBranchTarget = 16'd0;

    repeat (2) @(posedge Clock);
    #1;
    chk_reset_values("reset");
    chk("p2 reset halted", {31'd0, bus2.oHalted}, 32'd1);
    chk("p2 reset addr", {16'd0, bus2.oAddress}, 32'h1234);
    Reset = 1'b0;

    for (int i = 0; i < 36; i++) begin
      bus.iReady = vecs[i].rdy;  bus.iHalt = vecs[i].halt; bus.iStep = vecs[i].step;
      bus.iBranchTaken = vecs[i].br; bus.iBranchTarget = vecs[i].tgt;
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d valid", i),  {31'd0, bus.oValid},   {31'd0, vecs[i].valid});
      chk($sformatf("v%0d addr", i),   {16'd0, bus.oAddress}, {16'd0, vecs[i].addr});
      chk($sformatf("v%0d flush", i),  {31'd0, bus.oFlush},   {31'd0, vecs[i].flush});
      chk($sformatf("v%0d halted", i), {31'd0, bus.oHalted},  {31'd0, vecs[i].halted});
      chk($sformatf("v%0d count", i),  {16'd0, bus.oIssueCount}, {16'd0, vecs[i].cnt});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d ipc", i),   {16'd0, bus.oIssuePC}, {16'd0, vecs[i].ipc});
        chk($sformatf("v%0d instr", i), {4'd0, bus.oInstruction}, {16'd0, vecs[i].ipc});
      end
      if (i == 0) begin
        // second instance stays halted at its reset PC
        chk("p2 held halted", {31'd0, bus2.oHalted}, 32'd1);
        chk("p2 held valid", {31'd0, bus2.oValid}, 32'd0);
        bus2.iHalt = 1'b0;
      end
      if (i == 1) begin
        chk("p2 resume halted", {31'd0, bus2.oHalted}, 32'd0);
      end
      if (i == 2) begin
        chk("p2 first valid", {31'd0, bus2.oValid}, 32'd1);
        chk("p2 first ipc", {16'd0, bus2.oIssuePC}, 32'h1234);
      end
    end

    // asynchronous reset while an instruction is waiting on iReady=0
    Reset = 1'b1;
    #1;
    chk_reset_values("async reset");
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    bus.iReady = 1'b1;
    @(posedge Clock);
    #1;
    chk("restart valid", {31'd0, bus.oValid}, 32'd1);
    chk("restart ipc", {16'd0, bus.oIssuePC}, 32'd0);
    chk("restart addr", {16'd0, bus.oAddress}, 32'd1);
    chk("restart count", {16'd0, bus.oIssueCount}, 32'd0);

    // free run long enough to saturate the transfer counter
    repeat (65540) @(posedge Clock);
    #1;
    chk("count saturated", {16'd0, bus.oIssueCount}, 32'h0000FFFF);
    repeat (3) @(posedge Clock);
    #1;
    chk("count stays saturated", {16'd0, bus.oIssueCount}, 32'h0000FFFF);
    chk("valid after saturation", {31'd0, bus.oValid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
